control_unit: RTL and testbench

Hardwired Moore control sequencer for the single-bus CPU datapath. Each instruction runs as fetch (T0–T2), then an opcode-specific execute sequence. In each state it drives the datapath's one-hot bus-drive, register-load, ALU-select and memory strobes, and the datapath's `clk`/`clear` are shared with this block. It replaces hand-sequenced bench stimulus and is the first block that lets the datapath run programs out of RAM.

---
 rtl/cpu_ctrl_pkg.sv | 117 +++++++++++
 rtl/control_unit_if.sv | 32 +++
 rtl/ctrl_decode.sv | 43 ++++
 rtl/control_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer of the single-bus CPU.
// Holds the 5-bit opcode map, the sequencer state encoding, the opcode class
// seen by the FSM, the one-hot ALU select masks and the bundle of control
// strobes that the sequencer drives into the datapath.
package cpu_ctrl_pkg;

  // Opcode field IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // One-hot ALU operation select (IncPC is a fetch strobe, not part of this)
  localparam int ALU_W = 10;
  typedef logic [ALU_W-1:0] alu_sel_t;

  localparam alu_sel_t ALU_NONE = 10'b00_0000_0000;
  localparam alu_sel_t ALU_ADD  = 10'b00_0000_0001;
  localparam alu_sel_t ALU_SUB  = 10'b00_0000_0010;
  localparam alu_sel_t ALU_AND  = 10'b00_0000_0100;
  localparam alu_sel_t ALU_OR   = 10'b00_0000_1000;
  localparam alu_sel_t ALU_SHR  = 10'b00_0001_0000;
  localparam alu_sel_t ALU_SHL  = 10'b00_0010_0000;
  localparam alu_sel_t ALU_ROR  = 10'b00_0100_0000;
  localparam alu_sel_t ALU_ROL  = 10'b00_1000_0000;
  localparam alu_sel_t ALU_NEG  = 10'b01_0000_0000;
  localparam alu_sel_t ALU_NOT  = 10'b10_0000_0000;

  // Decoder select: ALU op plus the HI/LO choice for the move class
  typedef struct packed {
    logic     mv_hi;
    alu_sel_t alu;
  } dec_sel_t;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IDLE = 4'd1,
    S_T0   = 4'd2,
    S_T1   = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_T7   = 4'd9,
    S_HALT = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU_RR  = 4'd0,
    CLS_ALU_IMM = 4'd1,
    CLS_UNARY   = 4'd2,
    CLS_MOVE    = 4'd3,
    CLS_LDI     = 4'd4,
    CLS_LD      = 4'd5,
    CLS_ST      = 4'd6,
    CLS_NOP     = 4'd7,
    CLS_HALT    = 4'd8
  } op_class_e;

  // Every strobe the sequencer drives, registered as one word
  typedef struct packed {
    logic PCout;
    logic Zlowout;
    logic MDRout;
    logic HIout;
    logic LOout;
    logic Cout;
    logic BAout;
    logic Rout;
    logic MARin;
    logic Zin;
    logic PCin;
    logic MDRin;
    logic IRin;
    logic Yin;
    logic HIin;
    logic LOin;
    logic Rin;
    logic Gra;
    logic Grb;
    logic Grc;
    logic IncPC;
    logic ADD;
    logic SUB;
    logic AND;
    logic OR;
    logic SHR;
    logic SHL;
    logic ROR;
    logic ROL;
    logic NEG;
    logic NOT;
    logic Read;
    logic Write;
    logic run;
  } ctrl_out_t;

endpackage

// File: rtl/control_unit_if.sv
// Sequencer <-> datapath control bundle.
//   master : the control_unit (samples stop/IR, drives every strobe and run)
//   slave  : the datapath/bench side (drives stop/IR, observes the strobes)
interface control_unit_if;
  logic        stop;
  logic [31:0] IR;

  logic PCout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin;
  logic Gra, Grb, Grc;
  logic IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
  logic Read, Write;
  logic run;

  modport master (
    input  stop, IR,
    output PCout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin,
    output Gra, Grb, Grc,
    output IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    output Read, Write, run
  );

  modport slave (
    output stop, IR,
    input  PCout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin,
    input  Gra, Grb, Grc,
    input  IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    input  Read, Write, run
  );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode decoder for the control sequencer.
//   opcode : IR[31:27]
//   cls    : execute-sequence class used by the FSM
//   sel    : one-hot ALU select and the HI/LO choice for mfhi/mflo
// Address-computing instructions (ld, ldi, st) select ADD for the base+offset
// sum. Opcodes without an execute sequence (mul, div, branch, jump, I/O)
// fall into the nop class.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  cls,
  output dec_sel_t   sel
);

  always_comb begin
    cls = CLS_NOP;
    sel = '0;
    case (opcode)
      OP_LD:   begin cls = CLS_LD;      sel.alu = ALU_ADD; end
      OP_LDI:  begin cls = CLS_LDI;     sel.alu = ALU_ADD; end
      OP_ST:   begin cls = CLS_ST;      sel.alu = ALU_ADD; end
      OP_ADD:  begin cls = CLS_ALU_RR;  sel.alu = ALU_ADD; end
      OP_SUB:  begin cls = CLS_ALU_RR;  sel.alu = ALU_SUB; end
      OP_AND:  begin cls = CLS_ALU_RR;  sel.alu = ALU_AND; end
      OP_OR:   begin cls = CLS_ALU_RR;  sel.alu = ALU_OR;  end
      OP_SHR:  begin cls = CLS_ALU_RR;  sel.alu = ALU_SHR; end
      OP_SHL:  begin cls = CLS_ALU_RR;  sel.alu = ALU_SHL; end
      OP_ROR:  begin cls = CLS_ALU_RR;  sel.alu = ALU_ROR; end
      OP_ROL:  begin cls = CLS_ALU_RR;  sel.alu = ALU_ROL; end
      OP_ADDI: begin cls = CLS_ALU_IMM; sel.alu = ALU_ADD; end
      OP_ANDI: begin cls = CLS_ALU_IMM; sel.alu = ALU_AND; end
      OP_ORI:  begin cls = CLS_ALU_IMM; sel.alu = ALU_OR;  end
      OP_NEG:  begin cls = CLS_UNARY;   sel.alu = ALU_NEG; end
      OP_NOT:  begin cls = CLS_UNARY;   sel.alu = ALU_NOT; end
      OP_MFHI: begin cls = CLS_MOVE;    sel.mv_hi = 1'b1;  end
      OP_MFLO: begin cls = CLS_MOVE;    sel.mv_hi = 1'b0;  end
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the single-bus CPU datapath.
//   clk   : rising-edge clock shared with the datapath
//   clear : synchronous active-high reset, returns the sequencer to RST
//   bus   : control_unit_if.master
//           in : stop (honoured only at instruction boundaries, RST, IDLE),
//                IR (opcode in IR[31:27])
//           out: bus-drive selects, register loads, Gra/Grb/Grc, ALU selects,
//                Read/Write memory strobes, run
// Every instruction runs T0-T2 fetch followed by a class-specific execute
// sequence. All strobes come straight from flops: the output word for the
// state being entered is computed alongside the next state and registered
// with it, so nothing combinational reaches the outputs.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic clk,
  input  logic clear,
  control_unit_if.master bus
);

  state_e    state, state_nxt;
  op_class_e cls_q, cls_dec, cls_nxt;
  dec_sel_t  sel_q, sel_dec, sel_nxt;
  ctrl_out_t outs_q;
  state_e    end_state;

  // Only the opcode field matters to the sequencer
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.IR[26:0];

  ctrl_decode u_decode (
    .opcode (bus.IR[31:27]),
    .cls    (cls_dec),
    .sel    (sel_dec)
  );

  function automatic ctrl_out_t with_alu(input ctrl_out_t o_in, input alu_sel_t a);
    ctrl_out_t o;
    o     = o_in;
    o.ADD = |(a & ALU_ADD);
    o.SUB = |(a & ALU_SUB);
    o.AND = |(a & ALU_AND);
    o.OR  = |(a & ALU_OR);
    o.SHR = |(a & ALU_SHR);
    o.SHL = |(a & ALU_SHL);
    o.ROR = |(a & ALU_ROR);
    o.ROL = |(a & ALU_ROL);
    o.NEG = |(a & ALU_NEG);
    o.NOT = |(a & ALU_NOT);
    return o;
  endfunction

  // Strobe word for a given state and instruction class
  function automatic ctrl_out_t drive(input state_e s, input op_class_e c,
                                     input dec_sel_t sel);
    ctrl_out_t o;
    o     = '0;
    o.run = !(s inside {S_RST, S_IDLE, S_HALT});
    case (s)
      S_T0: begin
        o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin = 1'b1;
      end
      S_T1: begin
        o.Zlowout = 1'b1; o.PCin = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1;
      end
      S_T2: begin
        o.MDRout = 1'b1; o.IRin = 1'b1;
      end
      S_T3: begin
        case (c)
          CLS_ALU_RR, CLS_ALU_IMM: begin
            o.Grb = 1'b1; o.Rout = 1'b1; o.Yin = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            // Base register, with R0 reading as zero via BAout
            o.Grb = 1'b1; o.BAout = 1'b1; o.Yin = 1'b1;
          end
          CLS_UNARY: begin
            o = with_alu(o, sel.alu);
            o.Grb = 1'b1; o.Rout = 1'b1; o.Zin = 1'b1;
          end
          CLS_MOVE: begin
            o.HIout = sel.mv_hi; o.LOout = !sel.mv_hi;
            o.Gra = 1'b1; o.Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (c)
          CLS_ALU_RR: begin
            o = with_alu(o, sel.alu);
            o.Grc = 1'b1; o.Rout = 1'b1; o.Zin = 1'b1;
          end
          CLS_ALU_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
            o = with_alu(o, sel.alu);
            o.Cout = 1'b1; o.Zin = 1'b1;
          end
          CLS_UNARY: begin
            o.Zlowout = 1'b1; o.Gra = 1'b1; o.Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (c)
          CLS_ALU_RR, CLS_ALU_IMM, CLS_LDI: begin
            o.Zlowout = 1'b1; o.Gra = 1'b1; o.Rin = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            o.Zlowout = 1'b1; o.MARin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (c)
          CLS_LD: begin
            o.Read = 1'b1; o.MDRin = 1'b1;
          end
          CLS_ST: begin
            // Read stays low so MDR captures the bus (Ra) instead of RAM
            o.Gra = 1'b1; o.Rout = 1'b1; o.MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (c)
          CLS_LD: begin
            o.MDRout = 1'b1; o.Gra = 1'b1; o.Rin = 1'b1;
          end
          CLS_ST: o.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  // stop is looked at only when an instruction finishes
  assign end_state = bus.stop ? S_IDLE : S_T0;

  always_comb begin
    state_nxt = state;
    cls_nxt   = cls_q;
    sel_nxt   = sel_q;
    case (state)
      S_RST, S_IDLE: state_nxt = bus.stop ? S_IDLE : S_T0;
      S_T0: state_nxt = S_T1;
      S_T1: state_nxt = S_T2;
      S_T2: begin
        // Opcode class is captured as the FSM enters T3
        state_nxt = S_T3;
        cls_nxt   = cls_dec;
        sel_nxt   = sel_dec;
      end
      S_T3: begin
        case (cls_q)
          CLS_HALT:          state_nxt = S_HALT;
          CLS_MOVE, CLS_NOP: state_nxt = end_state;
          default:           state_nxt = S_T4;
        endcase
      end
      S_T4: state_nxt = (cls_q == CLS_UNARY) ? end_state : S_T5;
      S_T5: state_nxt = (cls_q == CLS_LD || cls_q == CLS_ST) ? S_T6 : end_state;
      S_T6: state_nxt = S_T7;
      S_T7: state_nxt = end_state;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  // State, latched class and registered strobes
  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= S_RST;
      cls_q  <= CLS_NOP;
      sel_q  <= '0;
      outs_q <= '0;
    end else begin
      state  <= state_nxt;
      cls_q  <= cls_nxt;
      sel_q  <= sel_nxt;
      outs_q <= drive(state_nxt, cls_nxt, sel_nxt);
    end
  end

  assign bus.PCout   = outs_q.PCout;
  assign bus.Zlowout = outs_q.Zlowout;
  assign bus.MDRout  = outs_q.MDRout;
  assign bus.HIout   = outs_q.HIout;
  assign bus.LOout   = outs_q.LOout;
  assign bus.Cout    = outs_q.Cout;
  assign bus.BAout   = outs_q.BAout;
  assign bus.Rout    = outs_q.Rout;
  assign bus.MARin   = outs_q.MARin;
  assign bus.Zin     = outs_q.Zin;
  assign bus.PCin    = outs_q.PCin;
  assign bus.MDRin   = outs_q.MDRin;
  assign bus.IRin    = outs_q.IRin;
  assign bus.Yin     = outs_q.Yin;
  assign bus.HIin    = outs_q.HIin;
  assign bus.LOin    = outs_q.LOin;
  assign bus.Rin     = outs_q.Rin;
  assign bus.Gra     = outs_q.Gra;
  assign bus.Grb     = outs_q.Grb;
  assign bus.Grc     = outs_q.Grc;
  assign bus.IncPC   = outs_q.IncPC;
  assign bus.ADD     = outs_q.ADD;
  assign bus.SUB     = outs_q.SUB;
  assign bus.AND     = outs_q.AND;
  assign bus.OR      = outs_q.OR;
  assign bus.SHR     = outs_q.SHR;
  assign bus.SHL     = outs_q.SHL;
  assign bus.ROR     = outs_q.ROR;
  assign bus.ROL     = outs_q.ROL;
  assign bus.NEG     = outs_q.NEG;
  assign bus.NOT     = outs_q.NOT;
  assign bus.Read    = outs_q.Read;
  assign bus.Write   = outs_q.Write;
  assign bus.run     = outs_q.run;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks reset, fetch and each execute class,
// comparing the complete strobe word after every clock edge.
module tb_control_unit;

  logic clk;
  logic clear;
  int   errors;
  int   checks;

  control_unit_if bus();

  control_unit dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bench-side ordering of the strobes; independent of the RTL packing
  localparam logic [33:0] M_PCOUT   = 34'h1 << 33;
  localparam logic [33:0] M_ZLOW    = 34'h1 << 32;
  localparam logic [33:0] M_MDROUT  = 34'h1 << 31;
  localparam logic [33:0] M_HIOUT   = 34'h1 << 30;
  localparam logic [33:0] M_LOOUT   = 34'h1 << 29;
  localparam logic [33:0] M_COUT    = 34'h1 << 28;
  localparam logic [33:0] M_BAOUT   = 34'h1 << 27;
  localparam logic [33:0] M_ROUT    = 34'h1 << 26;
  localparam logic [33:0] M_MARIN   = 34'h1 << 25;
  localparam logic [33:0] M_ZIN     = 34'h1 << 24;
  localparam logic [33:0] M_PCIN    = 34'h1 << 23;
  localparam logic [33:0] M_MDRIN   = 34'h1 << 22;
  localparam logic [33:0] M_IRIN    = 34'h1 << 21;
  localparam logic [33:0] M_YIN     = 34'h1 << 20;
  localparam logic [33:0] M_HIIN    = 34'h1 << 19;
  localparam logic [33:0] M_LOIN    = 34'h1 << 18;
  localparam logic [33:0] M_RIN     = 34'h1 << 17;
  localparam logic [33:0] M_GRA     = 34'h1 << 16;
  localparam logic [33:0] M_GRB     = 34'h1 << 15;
  localparam logic [33:0] M_GRC     = 34'h1 << 14;
  localparam logic [33:0] M_INCPC   = 34'h1 << 13;
  localparam logic [33:0] M_ADD     = 34'h1 << 12;
  localparam logic [33:0] M_SUB     = 34'h1 << 11;
  localparam logic [33:0] M_AND     = 34'h1 << 10;
  localparam logic [33:0] M_OR      = 34'h1 << 9;
  localparam logic [33:0] M_SHR     = 34'h1 << 8;
  localparam logic [33:0] M_SHL     = 34'h1 << 7;
  localparam logic [33:0] M_ROR     = 34'h1 << 6;
  localparam logic [33:0] M_ROL     = 34'h1 << 5;
  localparam logic [33:0] M_NEG     = 34'h1 << 4;
  localparam logic [33:0] M_NOT     = 34'h1 << 3;
  localparam logic [33:0] M_READ    = 34'h1 << 2;
  localparam logic [33:0] M_WRITE   = 34'h1 << 1;
  localparam logic [33:0] M_RUN     = 34'h1;

  // Expected words per state
  localparam logic [33:0] E_ZERO = 34'h0;
  localparam logic [33:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [33:0] E_T1   = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [33:0] E_T2   = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [33:0] E_RR3  = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [33:0] E_RR4  = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [33:0] E_WB   = M_ZLOW | M_GRA | M_RIN | M_RUN;
  localparam logic [33:0] E_IMM4 = M_COUT | M_ZIN | M_RUN;
  localparam logic [33:0] E_LD3  = M_GRB | M_BAOUT | M_YIN | M_RUN;
  localparam logic [33:0] E_LD4  = M_COUT | M_ADD | M_ZIN | M_RUN;
  localparam logic [33:0] E_LD5  = M_ZLOW | M_MARIN | M_RUN;
  localparam logic [33:0] E_LD6  = M_READ | M_MDRIN | M_RUN;
  localparam logic [33:0] E_LD7  = M_MDROUT | M_GRA | M_RIN | M_RUN;
  localparam logic [33:0] E_ST6  = M_GRA | M_ROUT | M_MDRIN | M_RUN;
  localparam logic [33:0] E_ST7  = M_WRITE | M_RUN;
  localparam logic [33:0] E_MFLO = M_LOOUT | M_GRA | M_RIN | M_RUN;
  localparam logic [33:0] E_MFHI = M_HIOUT | M_GRA | M_RIN | M_RUN;
  localparam logic [33:0] E_NEG3 = M_GRB | M_ROUT | M_NEG | M_ZIN | M_RUN;
  localparam logic [33:0] E_NOP3 = M_RUN;

  logic [33:0] obs;
  assign obs = {bus.PCout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout,
                bus.Cout, bus.BAout, bus.Rout,
                bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                bus.HIin, bus.LOin, bus.Rin,
                bus.Gra, bus.Grb, bus.Grc,
                bus.IncPC, bus.ADD, bus.SUB, bus.AND, bus.OR, bus.SHR,
                bus.SHL, bus.ROR, bus.ROL, bus.NEG, bus.NOT,
                bus.Read, bus.Write, bus.run};

  // Advance one clock and compare the strobe word just after the edge
  task automatic step(input string tag, input logic [33:0] exp);
    @(posedge clk);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag);
    step({tag, "_t1"}, E_T1);
    step({tag, "_t2"}, E_T2);
  endtask

  initial begin
    clk     = 1'b0;
    errors  = 0;
    checks  = 0;
    clear   = 1'b1;
    bus.stop = 1'b0;
    bus.IR   = 32'hDEADBEEF;

    // Reset held for three edges, then the first T0 one edge after release
    step("rst0", E_ZERO);
    step("rst1", E_ZERO);
    step("rst2", E_ZERO);
    clear = 1'b0;
    step("rel_t0", E_T0);

    // add R1,R2,R3
    bus.IR = 32'h18918000;
    fetch("add");
    step("add_t3", E_RR3);
    step("add_t4", E_RR4 | M_ADD);
    step("add_t5", E_WB);
    step("add_end", E_T0);

    // sub R1,R2,R3
    bus.IR = 32'h20918000;
    fetch("sub");
    step("sub_t3", E_RR3);
    step("sub_t4", E_RR4 | M_SUB);
    step("sub_t5", E_WB);
    step("sub_end", E_T0);

    // rol R1,R2,R3
    bus.IR = 32'h50918000;
    fetch("rol");
    step("rol_t3", E_RR3);
    step("rol_t4", E_RR4 | M_ROL);
    step("rol_t5", E_WB);
    step("rol_end", E_T0);

    // andi R1,R2,imm
    bus.IR = 32'h60900007;
    fetch("andi");
    step("andi_t3", E_RR3);
    step("andi_t4", E_IMM4 | M_AND);
    step("andi_t5", E_WB);
    step("andi_end", E_T0);

    // ld R1,0x55(R0)
    bus.IR = 32'h00800055;
    fetch("ld");
    step("ld_t3", E_LD3);
    step("ld_t4", E_LD4);
    step("ld_t5", E_LD5);
    step("ld_t6", E_LD6);
    step("ld_t7", E_LD7);
    step("ld_end", E_T0);

    // st 0x10(R0),R2
    bus.IR = 32'h11000010;
    fetch("st");
    step("st_t3", E_LD3);
    step("st_t4", E_LD4);
    step("st_t5", E_LD5);
    step("st_t6", E_ST6);
    step("st_t7", E_ST7);
    step("st_end", E_T0);

    // ldi R1,5(R2)
    bus.IR = 32'h08900005;
    fetch("ldi");
    step("ldi_t3", E_LD3);
    step("ldi_t4", E_LD4);
    step("ldi_t5", E_WB);
    step("ldi_end", E_T0);

    // neg R1,R2
    bus.IR = 32'h80900000;
    fetch("neg");
    step("neg_t3", E_NEG3);
    step("neg_t4", E_WB);
    step("neg_end", E_T0);

    // mflo R1
    bus.IR = 32'hC8800000;
    fetch("mflo");
    step("mflo_t3", E_MFLO);
    step("mflo_end", E_T0);

    // mfhi R1
    bus.IR = 32'hC0800000;
    fetch("mfhi");
    step("mfhi_t3", E_MFHI);
    step("mfhi_end", E_T0);

    // mul (no execute sequence)
    bus.IR = 32'h70000000;
    fetch("mul");
    step("mul_t3", E_NOP3);
    step("mul_end", E_T0);

    // stop raised during T4 of an add: T5 still completes, then IDLE
    bus.IR = 32'h18918000;
    fetch("stp");
    step("stp_t3", E_RR3);
    step("stp_t4", E_RR4 | M_ADD);
    bus.stop = 1'b1;
    step("stp_t5", E_WB);
    step("stp_idle0", E_ZERO);
    step("stp_idle1", E_ZERO);
    bus.stop = 1'b0;
    step("stp_resume", E_T0);

    // clear during T5 of an ld abandons it before any Rin
    bus.IR = 32'h00800055;
    fetch("clr");
    step("clr_t3", E_LD3);
    step("clr_t4", E_LD4);
    step("clr_t5", E_LD5);
    clear = 1'b1;
    step("clr_rst", E_ZERO);

    // clear and stop together: clear wins, then RST -> IDLE with stop held
    bus.stop = 1'b1;
    step("clrstp_rst", E_ZERO);
    clear = 1'b0;
    step("clrstp_idle", E_ZERO);
    bus.stop = 1'b0;
    step("clrstp_t0", E_T0);

    // halt parks the sequencer until clear
    bus.IR = 32'hD8000000;
    fetch("halt");
    step("halt_t3", E_NOP3);
    for (int i = 0; i < 20; i++) begin
      step("halt_hold", E_ZERO);
    end
    clear = 1'b1;
    step("halt_clr", E_ZERO);
    clear = 1'b0;
    step("halt_t0", E_T0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
